// File: rtl/apb_regfile_slave.sv
// APB completer with a small 32-bit register file.
//
// Registers 0..NUM_REGS-2 are read/write with byte-lane strobes. Register NUM_REGS-1 is
// read-only and always returns ID_VALUE. Each transfer passes through IDLE -> WAIT -> DONE,
// with WAIT_CYCLES wait states before PREADY is asserted.
//
// Ports:
//   ACLK, ARESETn       clock (rising edge) and asynchronous active-low reset
//   PSEL, PENABLE       APB select and access-phase strobe
//   PADDR, PWRITE       byte address and direction (1 = write)
//   PWDATA, PSTRB       write data and write byte lanes
//   PRDATA              read data, valid only in DONE of a good read, else 0
//   PREADY, PSLVERR     transfer complete / transfer error, both only in DONE
//   CTRL_OUT            live contents of register 0
module apb_regfile_slave #(
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic [31:0] PADDR,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  PSTRB,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] CTRL_OUT
);

   localparam int unsigned     IDX_W      = $clog2(NUM_REGS);
   localparam int unsigned     NUM_RW     = NUM_REGS - 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [31:0]     ADDR_LIMIT = 32'(NUM_REGS * 4);
   localparam logic [2:0]      CNT_INIT   = 3'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             write_q, write_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       strb_q, strb_d;
   logic             err_q, err_d;
   logic [31:0]      regs_q [NUM_RW];
   logic [31:0]      regs_d [NUM_RW];

   logic [IDX_W-1:0] setup_idx;
   logic             setup_err;
   logic [31:0]      rdata;

   // Decode the error condition at setup time so DONE only needs the latched flag.
   always_comb begin
      setup_idx = PADDR[IDX_W+1:2];
      setup_err = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT) ||
                  (PWRITE && (setup_idx == LAST_IDX));
   end

   // Transfer sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            // PENABLE=1 without a preceding setup phase is ignored here.
            if (PSEL && !PENABLE) begin
               idx_d   = setup_idx;
               write_d = PWRITE;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
               err_d   = setup_err;
               cnt_d   = CNT_INIT;
               state_d = (CNT_INIT == 3'd0) ? StDone : StWait;
            end
         end
         StWait: begin
            if (!PSEL) begin
               // Requester withdrew: abandon without committing anything.
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else if (PENABLE) begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Register file write: committed on the edge that leaves DONE.
   always_comb begin
      for (int i = 0; i < NUM_RW; i++) begin
         regs_d[i] = regs_q[i];
      end
      if ((state_q == StDone) && write_q && !err_q) begin
         for (int i = 0; i < NUM_RW; i++) begin
            if (idx_q == IDX_W'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (strb_q[b]) begin
                     regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Read mux: zero everywhere except DONE of a good read.
   always_comb begin
      rdata = 32'h0;
      if ((state_q == StDone) && !write_q && !err_q) begin
         if (idx_q == LAST_IDX) begin
            rdata = ID_VALUE;
         end else begin
            for (int i = 0; i < NUM_RW; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  rdata = regs_q[i];
               end
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= 32'h0;
         strb_q  <= 4'h0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_RW; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         err_q   <= err_d;
         for (int i = 0; i < NUM_RW; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign PREADY   = (state_q == StDone);
   assign PSLVERR  = (state_q == StDone) && err_q;
   assign PRDATA   = rdata;
   assign CTRL_OUT = regs_q[0];

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave. Three instances share clock, reset and APB
// payload signals; each has its own PSEL and outputs:
//   index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1, index 2: WAIT_CYCLES=3.
module tb_apb_regfile_slave;

   logic        clk;
   logic        arst_n;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pready;
   logic [2:0]  pslverr;
   logic [31:0] prdata   [3];
   logic [31:0] ctrl_out [3];

   int          tests;
   int          fails;
   logic [31:0] rd;
   logic        er;
   int          lt;

   apb_regfile_slave #(.WAIT_CYCLES(0)) u_w0 (
      .ACLK(clk), .ARESETn(arst_n), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
      .PREADY(pready[0]), .PSLVERR(pslverr[0]), .CTRL_OUT(ctrl_out[0])
   );

   apb_regfile_slave #(.WAIT_CYCLES(1)) u_w1 (
      .ACLK(clk), .ARESETn(arst_n), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
      .PREADY(pready[1]), .PSLVERR(pslverr[1]), .CTRL_OUT(ctrl_out[1])
   );

   apb_regfile_slave #(.WAIT_CYCLES(3)) u_w3 (
      .ACLK(clk), .ARESETn(arst_n), .PSEL(psel[2]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[2]),
      .PREADY(pready[2]), .PSLVERR(pslverr[2]), .CTRL_OUT(ctrl_out[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // Entered and left at posedge+1. Leaves PSEL high so a following call is back-to-back.
   // lt = cycles from the setup edge to the cycle where PREADY is seen; 99 on timeout.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err, output int lat);
      psel    = 3'b000;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      pstrb   = strb;
      @(posedge clk); #1;
      penable = 1'b1;
      lat     = 1;
      @(negedge clk);
      while (!pready[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         @(negedge clk);
      end
      if (!pready[d]) begin
         lat   = 99;
         rdata = 32'h0;
         err   = 1'b0;
      end else begin
         rdata = prdata[d];
         err   = pslverr[d];
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      psel    = 3'b000;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'h0;
      pwdata  = 32'h0;
      pstrb   = 4'h0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (pready[d] !== 1'b0) begin
            fails++;
            $display("FAIL reset_pready[%0d] got %b required 0", d, pready[d]);
         end
         tests++;
         if (pslverr[d] !== 1'b0) begin
            fails++;
            $display("FAIL reset_pslverr[%0d] got %b required 0", d, pslverr[d]);
         end
         tests++;
         if (prdata[d] !== 32'h0) begin
            fails++;
            $display("FAIL reset_prdata[%0d] got %h required 0", d, prdata[d]);
         end
         tests++;
         if (ctrl_out[d] !== 32'h0) begin
            fails++;
            $display("FAIL reset_ctrl_out[%0d] got %h required 0", d, ctrl_out[d]);
         end
      end
      @(posedge clk); #1;
      arst_n = 1'b1;
   endtask

   task automatic test_write();
      // First setup happens on the first edge after reset release.
      xfer(1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, er, lt);
      tests++;
      if (lt !== 2) begin
         fails++;
         $display("FAIL write_latency got %0d required 2", lt);
      end
      tests++;
      if (er !== 1'b0) begin
         fails++;
         $display("FAIL write_pslverr got %b required 0", er);
      end
      tests++;
      if (ctrl_out[1] !== 32'h1234_5678) begin
         fails++;
         $display("FAIL write_ctrl_out got %h required 12345678", ctrl_out[1]);
      end
      tests++;
      if (pready[1] !== 1'b0) begin
         fails++;
         $display("FAIL write_pready_after got %b required 0", pready[1]);
      end
      idle();
   endtask

   task automatic test_partial_write();
      xfer(1, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, rd, er, lt);
      tests++;
      if (er !== 1'b0) begin
         fails++;
         $display("FAIL partial_pslverr got %b required 0", er);
      end
      idle();
      xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (rd !== 32'h12BB_56DD) begin
         fails++;
         $display("FAIL partial_readback got %h required 12bb56dd", rd);
      end
      tests++;
      if (lt !== 2) begin
         fails++;
         $display("FAIL partial_read_latency got %0d required 2", lt);
      end
      tests++;
      if (ctrl_out[1] !== 32'h12BB_56DD) begin
         fails++;
         $display("FAIL partial_ctrl_out got %h required 12bb56dd", ctrl_out[1]);
      end
      idle();
   endtask

   task automatic test_errors();
      xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (er !== 1'b1) begin
         fails++;
         $display("FAIL err_range_pslverr got %b required 1", er);
      end
      tests++;
      if (rd !== 32'h0) begin
         fails++;
         $display("FAIL err_range_prdata got %h required 0", rd);
      end
      tests++;
      if (pslverr[1] !== 1'b0) begin
         fails++;
         $display("FAIL err_pslverr_outside_done got %b required 0", pslverr[1]);
      end
      idle();
      xfer(1, 1'b1, 32'h3C, 32'hFFFF_FFFF, 4'hF, rd, er, lt);
      tests++;
      if (er !== 1'b1) begin
         fails++;
         $display("FAIL err_id_write_pslverr got %b required 1", er);
      end
      idle();
      xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (er !== 1'b0) begin
         fails++;
         $display("FAIL id_read_pslverr got %b required 0", er);
      end
      tests++;
      if (rd !== 32'hA5B0_0001) begin
         fails++;
         $display("FAIL id_read_value got %h required a5b00001", rd);
      end
      tests++;
      if (prdata[1] !== 32'h0) begin
         fails++;
         $display("FAIL prdata_outside_done got %h required 0", prdata[1]);
      end
      idle();
      xfer(1, 1'b0, 32'h2, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (er !== 1'b1) begin
         fails++;
         $display("FAIL err_unaligned_read_pslverr got %b required 1", er);
      end
      tests++;
      if (rd !== 32'h0) begin
         fails++;
         $display("FAIL err_unaligned_read_prdata got %h required 0", rd);
      end
      idle();
      xfer(1, 1'b1, 32'h2, 32'h1111_1111, 4'hF, rd, er, lt);
      tests++;
      if (er !== 1'b1) begin
         fails++;
         $display("FAIL err_unaligned_write_pslverr got %b required 1", er);
      end
      idle();
      xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (rd !== 32'h12BB_56DD) begin
         fails++;
         $display("FAIL err_write_no_effect got %h required 12bb56dd", rd);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, rd, er, lt);
      tests++;
      if (lt !== 1) begin
         fails++;
         $display("FAIL b2b_write_latency got %0d required 1", lt);
      end
      // No idle: next setup phase follows DONE directly.
      xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (lt !== 1) begin
         fails++;
         $display("FAIL b2b_read_latency got %0d required 1", lt);
      end
      tests++;
      if (rd !== 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL b2b_read_value got %h required deadbeef", rd);
      end
      tests++;
      if (er !== 1'b0) begin
         fails++;
         $display("FAIL b2b_read_pslverr got %b required 0", er);
      end
      idle();
   endtask

   task automatic test_abort();
      logic seen;
      xfer(2, 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd, er, lt);
      tests++;
      if (lt !== 4) begin
         fails++;
         $display("FAIL abort_pre_write_latency got %0d required 4", lt);
      end
      idle();
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h0;
      pwdata  = 32'h2222_2222;
      pstrb   = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel    = 3'b000;
      penable = 1'b0;
      seen    = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | pready[2];
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL abort_pready_seen got %b required 0", seen);
      end
      @(posedge clk); #1;
      xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (rd !== 32'h1111_1111) begin
         fails++;
         $display("FAIL abort_reg_unchanged got %h required 11111111", rd);
      end
      tests++;
      if (lt !== 4) begin
         fails++;
         $display("FAIL abort_followup_latency got %0d required 4", lt);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h0;
      pwdata  = 32'h3333_3333;
      pstrb   = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      tests++;
      if (ctrl_out[2] !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid_ctrl_out2 got %h required 0", ctrl_out[2]);
      end
      tests++;
      if (ctrl_out[1] !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid_ctrl_out1 got %h required 0", ctrl_out[1]);
      end
      tests++;
      if ({pready[2], pslverr[2]} !== 2'b00) begin
         fails++;
         $display("FAIL rst_mid_flags got %b required 00", {pready[2], pslverr[2]});
      end
      tests++;
      if (prdata[2] !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid_prdata got %h required 0", prdata[2]);
      end
      psel    = 3'b000;
      penable = 1'b0;
      @(posedge clk); #1;
      arst_n = 1'b1;
      xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (rd !== 32'h0 || lt !== 4) begin
         fails++;
         $display("FAIL rst_mid_reg2 got %h/%0d required 0/4", rd, lt);
      end
      idle();
      xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (rd !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid_reg1 got %h required 0", rd);
      end
      idle();
      xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lt);
      tests++;
      if (rd !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid_reg0 got %h required 0", rd);
      end
      idle();
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      arst_n  = 1'b0;
      psel    = 3'b000;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'h0;
      pwdata  = 32'h0;
      pstrb   = 4'h0;
      test_reset();
      test_write();
      test_partial_write();
      test_errors();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
